// File: rtl/data_mem_unit_if.sv
// rtl/data_mem_unit_if.sv - request/response bundle between ctrl and the data memory unit
interface data_mem_unit_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  ready, done, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, done, rdata, err
    );
endinterface

// File: rtl/data_mem_unit.sv
// rtl/data_mem_unit.sv - multi-cycle load/store word memory with fixed wait latency
module data_mem_unit #(
    parameter int DEPTH = 1024,
    parameter int LAT   = 2
) (
    input  logic           clk,
    input  logic           rst_f,
    data_mem_unit_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          we_q;
    logic [15:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          ready_q;
    logic          done_q;
    logic          err_q;
    logic [31:0]   rdata_q;

    logic [31:0]   mem [DEPTH];

    logic          in_range;
    logic          access_now;
    logic [AW-1:0] idx;

    assign in_range   = ({16'd0, addr_q} < 32'(DEPTH));
    assign idx        = addr_q[AW-1:0];
    assign access_now = (state_q == S_WAIT) && (cnt_q == 4'd0);

    // ready is high only in IDLE, so a req seen in IDLE is always an accepted one;
    // requests in WAIT/DONE are dropped, not queued.
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 32'd0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (bus.req) begin
                        we_q    <= bus.we;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        cnt_q   <= 4'(LAT);
                        ready_q <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (in_range && !we_q) begin
                            rdata_q <= mem[idx];
                        end
                        done_q  <= 1'b1;
                        err_q   <= !in_range;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Array is kept out of the reset path; an abandoned store is blocked by rst_f.
    always_ff @(posedge clk) begin
        if (rst_f && access_now && we_q && in_range) begin
            mem[idx] <= wdata_q;
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
endmodule
